// File: rtl/prog_loader.sv
// Program store ahead of the controller: loads instruction words over a
// valid/ready channel in program mode and serves registered fetches.
module prog_loader #(
    parameter int VEC_ID_W       = 4,
    parameter int REGFILE_ADDR_W = 4,
    parameter int ALLOC_LEN_W    = 8,
    parameter int DATA_ADDR_W    = 10,
    parameter int PROG_SIZE      = 16,
    parameter int INSTR_ADDR_W   = $clog2(PROG_SIZE),
    parameter int INSTR_W        = 2 + VEC_ID_W + 2*REGFILE_ADDR_W + ALLOC_LEN_W + 2*DATA_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [INSTR_W-1:0]      ld_data,
    input  logic                    ld_last,
    input  logic                    fetch,
    input  logic [INSTR_ADDR_W-1:0] pc,
    output logic [INSTR_W-1:0]      instr_word,
    output logic                    instr_valid,
    output logic                    prog_loaded,
    output logic [INSTR_ADDR_W:0]   prog_len,
    output logic                    ovf_err,
    output logic                    range_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [INSTR_ADDR_W:0] PTR_ONE  = (INSTR_ADDR_W+1)'(1);
    localparam logic [INSTR_ADDR_W:0] PTR_LAST = (INSTR_ADDR_W+1)'(PROG_SIZE - 1);
    localparam logic [INSTR_ADDR_W:0] LEN_FULL = (INSTR_ADDR_W+1)'(PROG_SIZE);

    state_t                  state_r, state_s;
    logic [INSTR_ADDR_W:0]   wr_ptr_r, wr_ptr_s;
    logic [INSTR_ADDR_W:0]   prog_len_r, prog_len_s;
    logic                    ovf_r, ovf_s;
    logic                    range_r, range_s;
    logic                    iv_r, iv_s;
    logic [INSTR_W-1:0]      word_r, word_s;
    logic                    mem_we_s;
    logic [INSTR_ADDR_W:0]   pc_ext_s;
    logic [INSTR_W-1:0]      mem_r [PROG_SIZE];

    assign pc_ext_s = {1'b0, pc};

    // Next-state, load bookkeeping and fetch response.
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        prog_len_s = prog_len_r;
        ovf_s      = ovf_r;
        range_s    = range_r;
        iv_s       = 1'b0;
        word_s     = word_r;
        mem_we_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (prog) begin
                    state_s    = ST_LOAD;
                    wr_ptr_s   = '0;
                    prog_len_s = '0;
                    ovf_s      = 1'b0;
                    range_s    = 1'b0;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_LOAD: begin
                // A handshake takes precedence over prog dropping in the same cycle.
                if (ld_valid) begin
                    mem_we_s = 1'b1;
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    if (ld_last) begin
                        prog_len_s = wr_ptr_r + PTR_ONE;
                        state_s    = ST_READY;
                    end else if (wr_ptr_r == PTR_LAST) begin
                        prog_len_s = LEN_FULL;
                        ovf_s      = 1'b1;
                        state_s    = ST_READY;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (!prog) begin
                    state_s    = ST_EMPTY;
                    prog_len_s = '0;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_READY: begin
                if (prog) begin
                    state_s    = ST_LOAD;
                    wr_ptr_s   = '0;
                    prog_len_s = '0;
                    ovf_s      = 1'b0;
                    range_s    = 1'b0;
                end else if (fetch) begin
                    iv_s = 1'b1;
                    if (pc_ext_s < prog_len_r) begin
                        word_s = mem_r[pc];
                    end else begin
                        word_s  = '0;
                        range_s = 1'b1;
                    end
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            wr_ptr_r   <= '0;
            prog_len_r <= '0;
            ovf_r      <= 1'b0;
            range_r    <= 1'b0;
            iv_r       <= 1'b0;
            word_r     <= '0;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            prog_len_r <= prog_len_s;
            ovf_r      <= ovf_s;
            range_r    <= range_s;
            iv_r       <= iv_s;
            word_r     <= word_s;
        end
    end

    // Instruction memory; contents survive reset and are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[INSTR_ADDR_W-1:0]] <= ld_data;
        end
    end

    assign ld_ready    = (state_r == ST_LOAD);
    assign prog_loaded = (state_r == ST_READY);
    assign prog_len    = prog_len_r;
    assign ovf_err     = ovf_r;
    assign range_err   = range_r;
    assign instr_valid = iv_r;
    assign instr_word  = word_r;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program store directly upstream of the controller top.
- Accepts instruction words over a valid/ready load channel while `prog` is high, and holds them in an internal PROG_SIZE-deep memory.
- Answers controller fetches (`fetch`, `pc`) with a registered `instr_word`.
- Tracks loaded program length and flags overflow and out-of-range fetches.

Parameters:
- VEC_ID_W, 4, vector id field width
- REGFILE_ADDR_W, 4, register file address width
- ALLOC_LEN_W, 8, vector length field width
- DATA_ADDR_W, 10, data/coef RAM address width
- PROG_SIZE, 16, instruction memory depth in words, power of two ≥ 2
- INSTR_ADDR_W, $clog2(PROG_SIZE), pc width
- INSTR_W, 2+VEC_ID_W+2*REGFILE_ADDR_W+ALLOC_LEN_W+2*DATA_ADDR_W (42 at defaults), instruction word width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- prog  in  1  program mode request from host
- ld_valid  in  1  load word valid
- ld_ready  out  1  loader accepts word this cycle
- ld_data  in  INSTR_W  instruction word to store
- ld_last  in  1  marks final word of program, qualified by ld_valid&ld_ready
- fetch  in  1  controller fetch request
- pc  in  INSTR_ADDR_W  controller program counter
- instr_word  out  INSTR_W  fetched instruction, registered
- instr_valid  out  1  one-cycle pulse, instr_word updated this cycle
- prog_loaded  out  1  a complete program is resident
- prog_len  out  INSTR_ADDR_W+1  number of valid words, 0..PROG_SIZE
- ovf_err  out  1  sticky: load exceeded PROG_SIZE
- range_err  out  1  sticky: fetch with pc ≥ prog_len

Behaviour:
- Reset (`rst`=0, asynchronous): state=EMPTY; all outputs 0; wr_ptr=0. Memory contents are not cleared and are don't-care after reset.
- **EMPTY**:
  - ld_ready=0, prog_loaded=0.
  - prog=1 → LOAD next edge, with wr_ptr=0, prog_len=0, ovf_err=0, range_err=0.
  - fetch ignored: instr_valid stays 0, instr_word holds.
- **LOAD**: ld_ready=1 combinationally from state (not from ld_valid). On ld_valid&ld_ready, mem[wr_ptr]←ld_data and wr_ptr←wr_ptr+1, then:
  - ld_last=1 → prog_len←wr_ptr+1; state→READY.
  - ld_last=0 and wr_ptr==PROG_SIZE-1 → word stored; prog_len←PROG_SIZE; ovf_err←1; state→READY. Excess words are not accepted because ld_ready=0 outside LOAD.
  - prog=0 with no handshake this cycle (aborted load) → state→EMPTY; prog_len←0. Partial contents are discarded logically.
  - prog=0 in the same cycle as an accepted word → the handshake wins; the above rules apply to that word.
  - fetch ignored.
- **READY**:
  - prog_loaded=1, ld_ready=0.
  - fetch=1 and prog=0 → next edge: instr_word←mem[pc], instr_valid=1 for exactly that cycle. Read latency is 1 cycle.
  - If pc ≥ prog_len → instr_word←0 and range_err←1 (sticky until next LOAD entry); instr_valid still pulses.
  - Back-to-back fetches give one word per cycle.
  - No fetch → instr_word holds, instr_valid=0.
  - prog=1 → LOAD next edge (wr_ptr, prog_len and both errors cleared; prog_loaded drops). prog has priority over a simultaneous fetch; that fetch is dropped, with no instr_valid.
- Width rules:
  - wr_ptr is INSTR_ADDR_W+1 bits, so the PROG_SIZE count is representable.
  - The pc comparison is unsigned, with pc zero-extended.
- Reset mid-LOAD or mid-fetch: immediate return to EMPTY; a pending instr_valid never appears.
- Memory is written only by the LOAD handshake and read only in READY. No read-during-write case exists.

Test Plan:
- Reset, prog=1, load 3 words 0x1,0x2,0x3 with ld_last on the third → prog_len=3, prog_loaded=1, ovf_err=0. Fetch pc=0,1,2 back-to-back → instr_word 0x1,0x2,0x3, each one cycle after its fetch, instr_valid high 3 cycles.
- Load 16 words with no ld_last (PROG_SIZE=16) → after the 16th handshake ovf_err=1, prog_len=16, state READY, ld_ready=0. Fetch pc=15 → 16th word.
- After a 3-word load, fetch pc=5 → instr_word=0, instr_valid=1, range_err=1. range_err stays 1 on a later valid fetch, and clears on re-entry to LOAD.
- Abort: prog=1, 2 words accepted, prog drops without ld_last → state EMPTY, prog_len=0. fetch pc=0 → no instr_valid, instr_word unchanged.
- In READY, assert fetch and prog in the same cycle → no instr_valid, state LOAD, prog_loaded=0 next cycle.
- Assert rst low asynchronously mid-LOAD (between clock edges) → outputs 0 immediately, ld_ready=0. After release, state EMPTY and fetch is ignored.
